// File: rtl/multicycle_ctrl_pkg.sv
// Shared constants for the multi-cycle MIPS-subset control path: opcodes, funcs,
// ALU op codes, FSM state encodings and datapath mux select codes.
package multicycle_ctrl_pkg;

    localparam logic [5:0] OP_R_FORMAT = 6'h00;
    localparam logic [5:0] OP_LW       = 6'h23;
    localparam logic [5:0] OP_SW       = 6'h2B;
    localparam logic [5:0] OP_ADDI     = 6'h08;
    localparam logic [5:0] OP_BEQ      = 6'h04;
    localparam logic [5:0] OP_BNE      = 6'h05;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_ERR    = 3'd5;

    localparam logic [1:0] ASB_RDB    = 2'b00;
    localparam logic [1:0] ASB_FOUR   = 2'b01;
    localparam logic [1:0] ASB_IMM    = 2'b10;
    localparam logic [1:0] ASB_IMM_SH = 2'b11;

    localparam logic [1:0] PC_ALU = 2'b00;
    localparam logic [1:0] PC_TGT = 2'b01;

    typedef struct packed {
        logic       i_req;
        logic       d_ren;
        logic       d_wen;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       tgt_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_op;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       illegal;
    } ctrl_t;

    function automatic logic opcode_known(input logic [5:0] op);
        return op inside {OP_R_FORMAT, OP_LW, OP_SW, OP_ADDI, OP_BEQ, OP_BNE};
    endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_decode.sv
// R-type func field to ALU operation decode, with a legality flag.
// Shared between the multi-cycle and single-cycle controllers.
module alu_decode
    import multicycle_ctrl_pkg::*;
(
    input  logic [5:0] func,
    output logic [3:0] alu_op,
    output logic       legal
);

    always_comb begin
        alu_op = ALU_ADD;
        legal  = 1'b1;
        case (func)
            FN_ADD:  alu_op = ALU_ADD;
            FN_SUB:  alu_op = ALU_SUB;
            FN_AND:  alu_op = ALU_AND;
            FN_OR:   alu_op = ALU_OR;
            FN_NOR:  alu_op = ALU_NOR;
            FN_SLT:  alu_op = ALU_SLT;
            default: legal  = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/WB with ready-handshaked
// memories, a wait-limit watchdog and a retired-instruction counter.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int WAIT_LIMIT = 16,
    parameter int CNT_W      = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       func,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             i_req,
    output logic             d_ren,
    output logic             d_wen,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             tgt_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [3:0]       alu_op,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic [2:0]       state,
    output logic             err,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    localparam int WAIT_W = (WAIT_LIMIT > 2) ? $clog2(WAIT_LIMIT) : 1;

    logic [WAIT_W-1:0] wait_cnt;
    logic [2:0]        state_nxt;
    logic              retire;
    logic              wait_expired;
    logic [3:0]        r_alu_op;
    logic              r_legal;
    ctrl_t             c;

    logic is_r, is_lw, is_sw, is_addi, is_beq, is_bne, is_br, instr_legal;

    alu_decode u_alu_decode (
        .func   (func),
        .alu_op (r_alu_op),
        .legal  (r_legal)
    );

    assign is_r        = (opcode == OP_R_FORMAT);
    assign is_lw       = (opcode == OP_LW);
    assign is_sw       = (opcode == OP_SW);
    assign is_addi     = (opcode == OP_ADDI);
    assign is_beq      = (opcode == OP_BEQ);
    assign is_bne      = (opcode == OP_BNE);
    assign is_br       = is_beq | is_bne;
    assign instr_legal = opcode_known(opcode) & (~is_r | r_legal);
    assign wait_expired = (wait_cnt == WAIT_W'(WAIT_LIMIT - 1));

    always_comb begin
        c           = '0;
        c.alu_op    = ALU_ADD;
        state_nxt   = state;
        retire      = 1'b0;

        // No ALU output register: the EXEC operand selection is held through
        // MEM and WB so the address / result stays valid on the ALU output.
        if (state == S_EXEC || state == S_MEM || state == S_WB) begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = (is_r | is_br) ? ASB_RDB : ASB_IMM;
            c.alu_op    = is_r ? r_alu_op : (is_br ? ALU_SUB : ALU_ADD);
        end

        case (state)
            S_FETCH: begin
                c.i_req     = 1'b1;
                c.alu_src_b = ASB_FOUR;
                c.pc_src    = PC_ALU;
                if (mem_ready) begin
                    c.ir_write = 1'b1;
                    c.pc_write = 1'b1;
                    state_nxt  = S_DECODE;
                end else if (wait_expired) begin
                    state_nxt = S_ERR;
                end
            end
            S_DECODE: begin
                c.alu_src_b = ASB_IMM_SH;
                c.tgt_write = 1'b1;
                if (instr_legal) begin
                    state_nxt = S_EXEC;
                end else begin
                    c.illegal = 1'b1;
                    state_nxt = S_ERR;
                end
            end
            S_EXEC: begin
                if (is_r || is_addi) begin
                    state_nxt = S_WB;
                end else if (is_lw || is_sw) begin
                    state_nxt = S_MEM;
                end else if (is_br) begin
                    c.pc_src   = PC_TGT;
                    c.pc_write = (is_beq & zero) | (is_bne & ~zero);
                    retire     = 1'b1;
                    state_nxt  = S_FETCH;
                end else begin
                    state_nxt = S_ERR;
                end
            end
            S_MEM: begin
                c.d_ren = is_lw;
                c.d_wen = is_sw;
                if (mem_ready) begin
                    if (is_lw) begin
                        state_nxt = S_WB;
                    end else begin
                        retire    = 1'b1;
                        state_nxt = S_FETCH;
                    end
                end else if (wait_expired) begin
                    state_nxt = S_ERR;
                end
            end
            S_WB: begin
                c.reg_write  = 1'b1;
                c.reg_dst    = is_r;
                c.mem_to_reg = is_lw;
                retire       = 1'b1;
                state_nxt    = S_FETCH;
            end
            S_ERR:   state_nxt = S_ERR;
            default: state_nxt = S_ERR;
        endcase

        // Reset wins over everything, including a MEM write already in flight.
        if (!reset) begin
            c        = '0;
            c.alu_op = ALU_ADD;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= S_FETCH;
            wait_cnt    <= '0;
            instr_count <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state)
                wait_cnt <= '0;
            else if (state == S_FETCH || state == S_MEM)
                wait_cnt <= wait_cnt + 1'b1;
            if (retire)
                instr_count <= instr_count + 1'b1;
        end
    end

    assign i_req      = c.i_req;
    assign d_ren      = c.d_ren;
    assign d_wen      = c.d_wen;
    assign ir_write   = c.ir_write;
    assign pc_write   = c.pc_write;
    assign pc_src     = c.pc_src;
    assign tgt_write  = c.tgt_write;
    assign alu_src_a  = c.alu_src_a;
    assign alu_src_b  = c.alu_src_b;
    assign alu_op     = c.alu_op;
    assign reg_write  = c.reg_write;
    assign reg_dst    = c.reg_dst;
    assign mem_to_reg = c.mem_to_reg;
    assign illegal    = c.illegal;
    assign err        = (state == S_ERR);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: a directed vector table, hand-written corner sequences
// and randomized instruction streams checked against a per-instruction cycle plan.
module tb_multicycle_ctrl;

    localparam int WL = 16;
    localparam int CW = 3;

    localparam logic [5:0] R = 6'h00, LW = 6'h23, SW = 6'h2B, ADDI = 6'h08, BEQ = 6'h04, BNE = 6'h05;
    localparam logic [3:0] A_ADD = 4'b0010, A_SUB = 4'b0110;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [5:0]    opcode = '0, func = '0;
    logic          zero = 1'b0, mem_ready = 1'b0;
    logic          i_req, d_ren, d_wen, ir_write, pc_write, tgt_write, alu_src_a;
    logic          reg_write, reg_dst, mem_to_reg, err, illegal;
    logic [1:0]    pc_src, alu_src_b;
    logic [3:0]    alu_op;
    logic [2:0]    state;
    logic [CW-1:0] instr_count;

    multicycle_ctrl #(.WAIT_LIMIT(WL), .CNT_W(CW)) dut (
        .clock(clock), .reset(reset), .opcode(opcode), .func(func), .zero(zero),
        .mem_ready(mem_ready), .i_req(i_req), .d_ren(d_ren), .d_wen(d_wen),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .tgt_write(tgt_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .state(state), .err(err), .illegal(illegal), .instr_count(instr_count)
    );

    always #5 clock = ~clock;

    // Expected output word plus a mask of the fields that are defined in that cycle.
    // Layout: st[22:20] strobes[19:11] pc_src[10:9] a[8] b[7:6] op[5:2] rd[1] m2r[0]
    typedef struct packed { logic [22:0] v; logic [22:0] m; } ex_t;

    typedef struct {
        logic r; logic [5:0] o; logic [5:0] f; logic z; logic rd; ex_t e; int c;
    } vec_t;

    int total = 0;
    int bad   = 0;
    int cnt   = 0;

    // chk = {state, err, pc_src, alu, wb}
    function automatic ex_t pk(input logic [2:0] st, input logic [8:0] sb, input logic [1:0] ps,
                               input logic a, input logic [1:0] b, input logic [3:0] op,
                               input logic rd, input logic m2, input logic [4:0] chk);
        ex_t x;
        x.v = {st, sb, ps, a, b, op, rd, m2};
        x.m = {{3{chk[4]}}, 8'hFF, chk[3], {2{chk[2]}}, {7{chk[1]}}, {2{chk[0]}}};
        return x;
    endfunction

    function automatic logic [3:0] r_aop(input logic [5:0] fn);
        case (fn)
            6'h22:   return 4'b0110;
            6'h24:   return 4'b0000;
            6'h25:   return 4'b0001;
            6'h27:   return 4'b1100;
            6'h2A:   return 4'b0111;
            default: return 4'b0010;
        endcase
    endfunction

    function automatic logic legal(input logic [5:0] op, input logic [5:0] fn);
        if (op == R) return fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
        return op inside {LW, SW, ADDI, BEQ, BNE};
    endfunction

    function automatic ex_t f_fetch(input logic rdy);
        return pk(3'd0, {1'b1, 2'b00, rdy, rdy, 4'b0000}, 2'b00, 1'b0, 2'b01, A_ADD, 1'b0, 1'b0, 5'b11110);
    endfunction
    function automatic ex_t f_decode(input logic ill);
        return pk(3'd1, {5'b00000, 1'b1, 1'b0, ill, 1'b0}, 2'b00, 1'b0, 2'b11, A_ADD, 1'b0, 1'b0, 5'b11010);
    endfunction
    function automatic ex_t f_exec(input logic [5:0] op, input logic [5:0] fn, input logic z);
        logic pw;
        if (op == R)
            return pk(3'd2, 9'd0, 2'b00, 1'b1, 2'b00, r_aop(fn), 1'b0, 1'b0, 5'b11010);
        if (op == BEQ || op == BNE) begin
            pw = (op == BEQ) ? z : ~z;
            return pk(3'd2, {4'b0000, pw, 4'b0000}, 2'b01, 1'b1, 2'b00, A_SUB, 1'b0, 1'b0, 5'b11110);
        end
        return pk(3'd2, 9'd0, 2'b00, 1'b1, 2'b10, A_ADD, 1'b0, 1'b0, 5'b11010);
    endfunction
    function automatic ex_t f_mem(input logic [5:0] op);
        return pk(3'd3, {1'b0, op == LW, op == SW, 6'b000000}, 2'b00, 1'b1, 2'b10, A_ADD, 1'b0, 1'b0, 5'b11010);
    endfunction
    function automatic ex_t f_wb(input logic [5:0] op);
        return pk(3'd4, 9'b000000100, 2'b00, 1'b0, 2'b00, 4'd0, op == R, op == LW, 5'b11001);
    endfunction
    function automatic ex_t f_err();
        return pk(3'd5, 9'b000000001, 2'b00, 1'b0, 2'b00, 4'd0, 1'b0, 1'b0, 5'b11000);
    endfunction
    function automatic ex_t f_rst();
        ex_t x;
        x = pk(3'd0, 9'd0, 2'b00, 1'b0, 2'b00, A_ADD, 1'b0, 1'b0, 5'b00010);
        x.m[8:6] = 3'b000;
        return x;
    endfunction

    task automatic step(input logic r, input logic [5:0] o, input logic [5:0] f, input logic z,
                        input logic rd, input ex_t e, input int c, input string nm);
        logic [22:0] act;
        reset = r; opcode = o; func = f; zero = z; mem_ready = rd;
        @(negedge clock);
        act = {state, i_req, d_ren, d_wen, ir_write, pc_write, tgt_write, reg_write, illegal, err,
               pc_src, alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg};
        total++;
        if (((act ^ e.v) & e.m) !== 23'd0 || instr_count !== CW'(c)) begin
            bad++;
            $display("FAIL %s: got out=%06h cnt=%0d, want out=%06h (mask %06h) cnt=%0d",
                     nm, act, instr_count, e.v, e.m, c);
        end
        @(posedge clock);
        #1;
    endtask

    function automatic int inc(input int c);
        return (c + 1) % (1 << CW);
    endfunction

    vec_t tv[$];

    initial begin
        logic [5:0] rops [6];
        logic [5:0] rfns [6];
        rops = '{R, LW, SW, ADDI, BEQ, BNE};
        rfns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};

        tv.push_back('{1'b0, R,    6'h20, 1'b0, 1'b1, f_rst(),                   0});
        tv.push_back('{1'b1, R,    6'h20, 1'b0, 1'b1, f_fetch(1'b1),             0});
        tv.push_back('{1'b1, R,    6'h20, 1'b0, 1'b1, f_decode(1'b0),            0});
        tv.push_back('{1'b1, R,    6'h20, 1'b0, 1'b1, f_exec(R, 6'h20, 1'b0),    0});
        tv.push_back('{1'b1, R,    6'h20, 1'b0, 1'b1, f_wb(R),                   0});
        tv.push_back('{1'b1, BEQ,  6'h00, 1'b1, 1'b1, f_fetch(1'b1),             1});
        tv.push_back('{1'b1, BEQ,  6'h00, 1'b1, 1'b1, f_decode(1'b0),            1});
        tv.push_back('{1'b1, BEQ,  6'h00, 1'b1, 1'b1, f_exec(BEQ, 6'h00, 1'b1),  1});
        tv.push_back('{1'b1, BNE,  6'h00, 1'b1, 1'b1, f_fetch(1'b1),             2});
        tv.push_back('{1'b1, BNE,  6'h00, 1'b1, 1'b1, f_decode(1'b0),            2});
        tv.push_back('{1'b1, BNE,  6'h00, 1'b1, 1'b1, f_exec(BNE, 6'h00, 1'b1),  2});
        tv.push_back('{1'b1, ADDI, 6'h00, 1'b0, 1'b0, f_fetch(1'b0),             3});
        tv.push_back('{1'b1, ADDI, 6'h00, 1'b0, 1'b1, f_fetch(1'b1),             3});
        tv.push_back('{1'b1, ADDI, 6'h00, 1'b0, 1'b1, f_decode(1'b0),            3});
        tv.push_back('{1'b1, ADDI, 6'h00, 1'b0, 1'b1, f_exec(ADDI, 6'h00, 1'b0), 3});
        tv.push_back('{1'b1, ADDI, 6'h00, 1'b0, 1'b1, f_wb(ADDI),                3});
        tv.push_back('{1'b1, R,    6'h2A, 1'b0, 1'b1, f_fetch(1'b1),             4});
        tv.push_back('{1'b1, R,    6'h2A, 1'b0, 1'b0, f_decode(1'b0),            4});
        tv.push_back('{1'b1, R,    6'h2A, 1'b0, 1'b0, f_exec(R, 6'h2A, 1'b0),    4});
        tv.push_back('{1'b1, R,    6'h2A, 1'b0, 1'b0, f_wb(R),                   4});
        tv.push_back('{1'b1, R,    6'h27, 1'b0, 1'b0, f_fetch(1'b0),             5});

        repeat (2) @(posedge clock);
        #1;
        foreach (tv[i]) step(tv[i].r, tv[i].o, tv[i].f, tv[i].z, tv[i].rd, tv[i].e, tv[i].c,
                             $sformatf("tbl%0d", i));
        cnt = 5;

        // LW with data memory ready after 3 wait cycles: 8 cycles total.
        step(1, LW, 0, 0, 1, f_fetch(1), cnt, "lw fetch");
        step(1, LW, 0, 0, 1, f_decode(0), cnt, "lw decode");
        step(1, LW, 0, 0, 1, f_exec(LW, 0, 0), cnt, "lw exec");
        for (int k = 0; k < 3; k++) step(1, LW, 0, 0, 0, f_mem(LW), cnt, "lw mem wait");
        step(1, LW, 0, 0, 1, f_mem(LW), cnt, "lw mem ready");
        step(1, LW, 0, 0, 1, f_wb(LW), cnt, "lw wb");
        cnt = inc(cnt);
        step(1, LW, 0, 0, 0, f_fetch(0), cnt, "lw retired");

        // Illegal opcode: pulse in DECODE, then ERR is terminal until reset.
        step(1, 6'h3F, 0, 0, 1, f_fetch(1), cnt, "ill fetch");
        step(1, 6'h3F, 0, 0, 1, f_decode(1), cnt, "ill decode");
        for (int k = 0; k < 3; k++) step(1, 6'h3F, 0, 0, 1, f_err(), cnt, "ill err");
        step(0, R, 6'h20, 0, 1, f_rst(), cnt, "ill reset");
        cnt = 0;
        // Illegal func on an R-type.
        step(1, R, 6'h21, 0, 1, f_fetch(1), cnt, "badfn fetch");
        step(1, R, 6'h21, 0, 0, f_decode(1), cnt, "badfn decode");
        step(1, R, 6'h21, 0, 0, f_err(), cnt, "badfn err");
        step(0, R, 6'h20, 0, 0, f_rst(), cnt, "badfn reset");

        // Fetch timeout: ERR exactly WL cycles after entering FETCH.
        for (int k = 0; k < WL; k++) step(1, R, 6'h20, 0, 0, f_fetch(0), cnt, "ftimeout wait");
        step(1, R, 6'h20, 0, 0, f_err(), cnt, "ftimeout err");
        step(0, R, 6'h20, 0, 0, f_rst(), cnt, "ftimeout reset");

        // Data memory timeout.
        step(1, SW, 0, 0, 1, f_fetch(1), cnt, "mtimeout fetch");
        step(1, SW, 0, 0, 1, f_decode(0), cnt, "mtimeout decode");
        step(1, SW, 0, 0, 1, f_exec(SW, 0, 0), cnt, "mtimeout exec");
        for (int k = 0; k < WL; k++) step(1, SW, 0, 0, 0, f_mem(SW), cnt, "mtimeout wait");
        step(1, SW, 0, 0, 1, f_err(), cnt, "mtimeout err");
        step(0, SW, 0, 0, 0, f_rst(), cnt, "mtimeout reset");

        // One SW retires, a second is aborted by reset while in MEM.
        step(1, SW, 0, 0, 1, f_fetch(1), cnt, "sw fetch");
        step(1, SW, 0, 0, 1, f_decode(0), cnt, "sw decode");
        step(1, SW, 0, 0, 1, f_exec(SW, 0, 0), cnt, "sw exec");
        step(1, SW, 0, 0, 1, f_mem(SW), cnt, "sw mem");
        cnt = inc(cnt);
        step(1, SW, 0, 0, 1, f_fetch(1), cnt, "sw2 fetch");
        step(1, SW, 0, 0, 1, f_decode(0), cnt, "sw2 decode");
        step(1, SW, 0, 0, 1, f_exec(SW, 0, 0), cnt, "sw2 exec");
        step(1, SW, 0, 0, 0, f_mem(SW), cnt, "sw2 mem wait");
        step(0, SW, 0, 0, 1, f_rst(), cnt, "sw2 reset in mem");
        cnt = 0;
        step(1, SW, 0, 0, 0, f_fetch(0), cnt, "after reset");

        // Random instruction stream; CW=3 so the counter wraps many times.
        for (int n = 0; n < 300; n++) begin
            logic [5:0] op, fn;
            logic       z, ok;
            int         df, dm;
            op = rops[$urandom_range(0, 5)];
            if ($urandom_range(0, 19) == 0) begin
                op = 6'($urandom);
                while (legal(op, 6'h20)) op = 6'($urandom);
            end
            fn = (op == R && $urandom_range(0, 9) != 0) ? rfns[$urandom_range(0, 5)] : 6'($urandom);
            z  = 1'($urandom);
            df = $urandom_range(0, 3);
            dm = $urandom_range(0, 3);
            ok = legal(op, fn);
            for (int k = 0; k < df; k++) step(1, op, fn, z, 0, f_fetch(0), cnt, "rnd fetch wait");
            step(1, op, fn, z, 1, f_fetch(1), cnt, "rnd fetch");
            step(1, op, fn, z, 1'($urandom), f_decode(!ok), cnt, "rnd decode");
            if (!ok) begin
                step(1, op, fn, z, 1'($urandom), f_err(), cnt, "rnd err");
                step(0, op, fn, z, 1'($urandom), f_rst(), cnt, "rnd reset");
                cnt = 0;
                continue;
            end
            step(1, op, fn, z, 1'($urandom), f_exec(op, fn, z), cnt, "rnd exec");
            if (op == BEQ || op == BNE) begin
                cnt = inc(cnt);
                continue;
            end
            if (op == LW || op == SW) begin
                for (int k = 0; k < dm; k++) step(1, op, fn, z, 0, f_mem(op), cnt, "rnd mem wait");
                step(1, op, fn, z, 1, f_mem(op), cnt, "rnd mem");
                if (op == SW) begin
                    cnt = inc(cnt);
                    continue;
                end
            end
            step(1, op, fn, z, 1'($urandom), f_wb(op), cnt, "rnd wb");
            cnt = inc(cnt);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
